at93c46d_ctrl: RTL
==================

// Module: at93c46d_ctrl
// PURPOSE
//  Request sequencer that sits directly upstream of the AT93C46D SPI engine.
//  - Accepts one READ or WRITE request at a time on a valid/ready port.
//  - Drives the engine's cmd, data_in and start inputs, and tracks its cs output to detect completion.
//  - Captures read data and holds off the write-programming time (tWP).
//  - Returns exactly one response per request.
// PARAMETERS
//  WR_WAIT_CYCLES  625000  post-WRITE programming hold (5 ms @ 125 MHz)
//  GAP_CYCLES      4       idle cycles forced between transactions, min 1
//  TIMEOUT_CYCLES  8192    watchdog limit per phase, used only with AT93C46D_CTRL_TIMEOUT_EN
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when valid&ready
//  req_write    in   1   1=WRITE (op 2'b01), 0=READ (op 2'b10)
//  req_addr     in   6   EEPROM word address
//  req_wdata    in   16  write data
//  rsp_valid    out  1   one-cycle response strobe
//  rsp_rdata    out  16  read data (0 for WRITE)
//  rsp_error    out  1   watchdog expired (0 when feature off)
//  busy         out  1   state != IDLE
//  spi_cmd      out  8   {op[1:0], addr[5:0]} to engine
//  spi_data_in  out  16  write data to engine
//  spi_start    out  1   engine start; engine triggers on the rising edge
//  spi_cs       in   1   engine chip select; high while a transaction runs
//  spi_data_out in   16  engine read result; valid in the cycle spi_cs is first seen low
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0,
//  spi_start=0, spi_cmd=0, spi_data_in=0. State=IDLE, counters=0.
//  req_ready = (state==IDLE) & ~spi_cs & ~rst. The engine has no reset and may
//  still be mid-transaction after rst; the ~spi_cs term blocks new requests until it finishes.
//  States:
//  - IDLE: on valid&ready, register cmd and wdata into spi_cmd/spi_data_in, then go to START.
//  - START: spi_start=1 for exactly one cycle, then go to ARM.
//  - ARM: spi_start=0; wait for spi_cs=1, then go to BUSY.
//  - BUSY: wait for spi_cs=0.
//    - READ: on that cycle, capture spi_data_out into rsp_rdata and go to RESP.
//    - WRITE: go to WR_WAIT.
//  - WR_WAIT: count WR_WAIT_CYCLES cycles, then go to RESP.
//  - RESP: rsp_valid=1 for one cycle, then go to GAP.
//  - GAP: GAP_CYCLES cycles with spi_start=0, then go to IDLE.
//  Stability rules:
//  - spi_cmd and spi_data_in stay stable from START through the end of BUSY, because the engine
//    reads data_in live during its write phase. They change only on acceptance.
//  - spi_start is 0 in every state except START, so the next request always produces a fresh
//    rising edge.
//  Latency: acceptance -> spi_start high is 1 cycle. rsp_valid follows the spi_cs fall by 1 cycle
//  for READ, and by WR_WAIT_CYCLES+1 cycles for WRITE.
//  Other rules:
//  - rsp_rdata holds its value until the next READ response. A WRITE response sets rsp_rdata=0.
//  - req_valid while busy is ignored; no buffering, and the requester must hold its request.
//  - rst in any state: go to IDLE immediately, drop spi_start, emit no response.
//  - Counters are wide enough for max(WR_WAIT_CYCLES, TIMEOUT_CYCLES) and saturate, never wrap.
// CONFIGURATION
//  AT93C46D_CTRL_TIMEOUT_EN defined:
//  - One counter runs in ARM and BUSY and clears on each state entry.
//  - Reaching TIMEOUT_CYCLES goes to RESP with rsp_error=1, rsp_rdata=0.
//  - The next request is still gated by ~spi_cs.
//  Macro undefined: ARM and BUSY wait forever; rsp_error is tied 0; no timeout counter is built.
// TESTING
//  - Engine model: cs high 2 cycles after the start edge, low 3456 cycles later.
//    READ addr 6'h05, model data 16'hBEEF -> spi_cmd=8'h85; one rsp_valid, rdata=16'hBEEF, error=0.
//  - WRITE addr 6'h3F, wdata 16'h1234 -> spi_cmd=8'h7F; spi_data_in=16'h1234 stable through cs low;
//    rsp_valid exactly WR_WAIT_CYCLES+1 cycles after cs falls; rdata=0.
//  - Back-to-back READ 6'h01, READ 6'h02 with valid held -> second accepted only after GAP;
//    exactly 2 spi_start rising edges and 2 responses, in order.
//  - rst pulse while in BUSY with model cs still high -> outputs return to reset values;
//    req_ready stays 0 until cs falls, then 1; no rsp_valid.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=16, model never raises cs -> rsp_error=1, rdata=0 at ARM cycle 16;
//    without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/at93c46d_ctrl.sv
// Request sequencer in front of the AT93C46D SPI engine: one READ/WRITE at a time, one response each.
// Optional per-phase watchdog enabled by defining AT93C46D_CTRL_TIMEOUT_EN.
module at93c46d_ctrl #(
  parameter int unsigned WR_WAIT_CYCLES = 625000,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [5:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [7:0]  spi_cmd,
  output logic [15:0] spi_data_in,
  output logic        spi_start,
  input  logic        spi_cs,
  input  logic [15:0] spi_data_out
);

  localparam int unsigned MAX_WT  = (WR_WAIT_CYCLES > TIMEOUT_CYCLES) ? WR_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_WT > GAP_CYCLES) ? MAX_WT : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WR_LAST  = CW'((WR_WAIT_CYCLES > 0) ? WR_WAIT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ARM, S_BUSY, S_WR_WAIT, S_RESP, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          wr_q, wr_d;
  logic          accept;
  logic          timeout;

  // The engine has no reset, so a transfer may still be running after rst.
  assign req_ready   = (state_q == S_IDLE) & ~spi_cs & ~rst;
  assign accept      = req_valid & req_ready;
  assign spi_start   = (state_q == S_START);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign spi_cmd     = cmd_q;
  assign spi_data_in = wdata_q;
  assign rsp_rdata   = rdata_q;

`ifdef AT93C46D_CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic err_q;

  assign timeout = (cnt_q >= TO_LAST);

  // ARM->RESP is always a timeout; BUSY->RESP is one only while cs is still high.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_d == S_RESP && state_q != S_RESP)
      err_q <= (state_q == S_ARM) | ((state_q == S_BUSY) & spi_cs);
  end
  assign rsp_error = err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = {(req_write ? 2'b01 : 2'b10), req_addr};
          wdata_d = req_wdata;
          wr_d    = req_write;
          state_d = S_START;
        end
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        if (spi_cs) begin
          state_d = S_BUSY;
        end else if (timeout) begin
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_BUSY: begin
        if (!spi_cs) begin
          if (wr_q) begin
            state_d = S_WR_WAIT;
          end else begin
            rdata_d = spi_data_out;
            state_d = S_RESP;
          end
        end else if (timeout) begin
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q >= WR_LAST) begin
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_GAP;
      S_GAP: begin
        if (cnt_q >= GAP_LAST)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One shared counter: cleared on every state entry, saturating otherwise.
    if (state_d != state_q || state_q == S_IDLE)
      cnt_d = '0;
    else if (cnt_q == '1)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

endmodule
